tof_i2c_arbiter: RTL and testbench
==================================

Name: tof_i2c_arbiter

Overview:
- Shares one I2C master between N_REQ ToF sensor controllers, one per sensor.
- Each requester presents its transaction fields: register address, read flag, byte count and write byte.
- Grants are round-robin. A granted requester can lock the bus across multi-byte bursts, such as firmware download or the 180-byte ranging read.
- A watchdog releases the bus if the master stalls.

Parameters:
N_REQ, 4, number of requesting sensor controllers
TIMEOUT_CYCLES, 100000, max cycles per transfer or per idle lock hold before an error release
CNT_W, 17, width of the watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  requester i has a byte transfer pending
req_lock  in  N_REQ  requester i keeps the bus after the current transfer
req_addr  in  N_REQ*16  register address per requester
req_is_read  in  N_REQ  1 = read, 0 = write
req_nb_bytes  in  N_REQ*17  remaining-bytes field, forwarded unchanged
req_wdata  in  N_REQ*8  write byte per requester
grant  out  N_REQ  one-hot owner of the bus, 0 when free
req_done  out  N_REQ  1-cycle pulse: transfer complete for owner
req_error  out  N_REQ  1-cycle pulse: master error or timeout for owner
req_rdata  out  8  read byte, valid with req_done
m_start  out  1  start to the I2C master
m_addr  out  16  forwarded address
m_is_read  out  1  forwarded read flag
m_nb_bytes  out  17  forwarded byte count
m_wdata  out  8  forwarded write byte
m_ready  in  1  master idle / byte done (high = idle)
m_error  in  1  master NACK/bus error
m_rdata  in  8  master read byte
busy  out  1  grant != 0

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, rr pointer = N_REQ-1, counter 0. An in-flight transfer is abandoned with no done/error pulse.
- States: IDLE, ISSUE, WAIT_DONE, HOLD.
- IDLE, any req_valid at cycle t:
  - Winner = first set bit searching from pointer+1, wrapping modulo N_REQ.
  - At t+1: grant one-hot, m_* fields captured from the winner, m_start=1, state ISSUE, counter cleared.
- ISSUE:
  - m_start held high until m_ready seen low, then m_start=0 and state WAIT_DONE.
  - Fields stay frozen; requester changes after capture are ignored.
- WAIT_DONE: on m_ready high:
  - req_rdata <= m_rdata and req_done[owner] pulses next cycle.
  - If req_lock[owner]=1: state HOLD, grant kept.
  - Else: grant cleared, pointer <= owner, state IDLE.
- m_error high in ISSUE or WAIT_DONE:
  - req_error[owner] pulses; no req_done.
  - m_start=0, grant cleared, pointer <= owner, IDLE.
  - Takes precedence over a simultaneous m_ready.
- HOLD:
  - req_valid[owner]=1: recapture fields, m_start=1, ISSUE, with no arbitration. Other requesters wait.
  - req_lock[owner]=0 and req_valid[owner]=0: release, pointer <= owner, IDLE.
  - req_lock[owner]=0 and req_valid[owner]=1: issue one last transfer first.
- Watchdog:
  - Counter increments each cycle in ISSUE, WAIT_DONE and HOLD; cleared on every state entry.
  - At TIMEOUT_CYCLES-1: req_error[owner] pulse, m_start=0, release, pointer <= owner, IDLE.
- Fairness:
  - After any release, the releasing owner has lowest priority.
  - Back-to-back grants have 1 IDLE cycle between them (grant=0 for one cycle).
- Latency: req_valid to m_start is 1 cycle. m_ready rise to req_done is 1 cycle.
- A requester dropping req_valid while waiting (not granted) simply loses nothing; no state is kept per waiter.

Decomposition:
- Package tof_bus_pkg holds:
  - constants TOF_ADDR_W=16, TOF_NB_W=17, TOF_DATA_W=8
  - enum arb_state_t {IDLE, ISSUE, WAIT_DONE, HOLD}
  - struct tof_xfer_t {addr, is_read, nb_bytes, wdata}
- Sub-module rr_select: combinational round-robin picker taking req vector and pointer, returning one-hot winner plus valid. Parameterised by N_REQ.

Test Plan:
- Single read: req_valid[0]=1, addr 0x0000, is_read=1; master drops m_ready 2 cycles after m_start, raises it 10 cycles later with m_rdata=0xA5 -> grant=0001 at t+1; req_done[0] pulses once; req_rdata=0xA5; grant=0 afterwards.
- Round-robin: req_valid=1111 held, each transfer completes -> grant order 0001, 0010, 0100, 1000, 0001, each separated by one grant=0 cycle.
- Lock burst: requester 2 with req_lock=1 issues 5 writes 0x11..0x15 while req_valid[1]=1 continuously -> all 5 forwarded on m_wdata in order with grant=0100 throughout; requester 1 is granted only after req_lock[2] falls.
- Timeout: TIMEOUT_CYCLES=50, m_ready never drops -> req_error[owner] pulses 50 cycles after ISSUE entry; m_start=0; bus freed; next requester granted.
- m_error with m_ready in the same cycle during WAIT_DONE -> req_error pulses, no req_done, grant cleared.
- Async reset asserted mid-WAIT_DONE -> all outputs 0 immediately, without waiting for a clock edge; after release the first grant goes to requester 0 when req_valid=1111.

Source files
------------

// File: rtl/tof_bus_pkg.sv
// Shared types and widths for the ToF sensor I2C arbiter.
// Holds the field widths of a byte transfer, the arbiter state encoding
// and the packed transfer payload forwarded to the I2C master.
package tof_bus_pkg;

    localparam int unsigned TOF_ADDR_W = 16;
    localparam int unsigned TOF_NB_W   = 17;
    localparam int unsigned TOF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLD
    } arb_state_t;

    typedef struct packed {
        logic [TOF_ADDR_W-1:0] addr;
        logic                  is_read;
        logic [TOF_NB_W-1:0]   nb_bytes;
        logic [TOF_DATA_W-1:0] wdata;
    } tof_xfer_t;

endpackage

// File: rtl/tof_i2c_arbiter_if.sv
// Requester and I2C-master signals of the ToF arbiter.
// slave  : arbiter view (takes requests, drives grant/done/error and m_*).
// master : environment view (sensor controllers plus the I2C master engine).
interface tof_i2c_arbiter_if
    import tof_bus_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_lock;
    logic [N_REQ-1:0][TOF_ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]                 req_is_read;
    logic [N_REQ-1:0][TOF_NB_W-1:0]   req_nb_bytes;
    logic [N_REQ-1:0][TOF_DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]                 grant;
    logic [N_REQ-1:0]                 req_done;
    logic [N_REQ-1:0]                 req_error;
    logic [TOF_DATA_W-1:0]            req_rdata;
    logic                             m_start;
    logic [TOF_ADDR_W-1:0]            m_addr;
    logic                             m_is_read;
    logic [TOF_NB_W-1:0]              m_nb_bytes;
    logic [TOF_DATA_W-1:0]            m_wdata;
    logic                             m_ready;
    logic                             m_error;
    logic [TOF_DATA_W-1:0]            m_rdata;
    logic                             busy;

    modport slave (
        input  req_valid, req_lock, req_addr, req_is_read, req_nb_bytes, req_wdata,
        input  m_ready, m_error, m_rdata,
        output grant, req_done, req_error, req_rdata,
        output m_start, m_addr, m_is_read, m_nb_bytes, m_wdata, busy
    );

    modport master (
        output req_valid, req_lock, req_addr, req_is_read, req_nb_bytes, req_wdata,
        output m_ready, m_error, m_rdata,
        input  grant, req_done, req_error, req_rdata,
        input  m_start, m_addr, m_is_read, m_nb_bytes, m_wdata, busy
    );

endinterface

// File: rtl/tof_i2c_arbiter_rr_select.sv
// Combinational round-robin picker.
// req_i   : pending requests
// ptr_i   : index of the last owner (lowest priority)
// gnt_c   : one-hot winner, first set bit after ptr_i, wrapping
// idx_c   : index of the winner
// valid_c : any request present
module rr_select #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    logic [31:0] cand;

    // Scan ptr+1 .. ptr+N_REQ so the last owner is considered last.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_i) + k) % N_REQ;
            if (!valid_c && req_i[IDX_W'(cand)]) begin
                valid_c                = 1'b1;
                gnt_c[IDX_W'(cand)]    = 1'b1;
                idx_c                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tof_i2c_arbiter.sv
// Shares one I2C master between N_REQ ToF sensor controllers.
// Round-robin grants, optional bus lock across multi-byte bursts,
// and a watchdog that releases the bus when the master stalls.
// clk, reset : clock, asynchronous active-high reset
// bus        : requester fields in, grant/done/error/rdata out,
//              m_* forwarded to the I2C master, busy out
module tof_i2c_arbiter
    import tof_bus_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic              clk,
    input  logic              reset,
    tof_i2c_arbiter_if.slave  bus
);

    localparam int unsigned     IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t            state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic [N_REQ-1:0]      error_q, error_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    tof_xfer_t             xfer_q, xfer_d;
    logic                  m_start_q, m_start_d;
    logic [TOF_DATA_W-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;

    logic [N_REQ-1:0]      win_c;
    logic [IDX_W-1:0]      win_idx_c;
    logic                  win_valid_c;
    logic [IDX_W-1:0]      cap_idx_c;
    tof_xfer_t             cap_xfer_c;
    logic                  timeout_c;
    logic                  release_c;
    logic                  fault_c;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_c   (win_c),
        .idx_c   (win_idx_c),
        .valid_c (win_valid_c)
    );

    // A locked owner recaptures its own fields; otherwise the arbitration winner's.
    assign cap_idx_c           = (state_q == HOLD) ? owner_q : win_idx_c;
    assign cap_xfer_c.addr     = bus.req_addr[cap_idx_c];
    assign cap_xfer_c.is_read  = bus.req_is_read[cap_idx_c];
    assign cap_xfer_c.nb_bytes = bus.req_nb_bytes[cap_idx_c];
    assign cap_xfer_c.wdata    = bus.req_wdata[cap_idx_c];
    assign timeout_c           = (cnt_q == CNT_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        xfer_d    = xfer_q;
        m_start_d = m_start_q;
        rdata_d   = rdata_q;
        done_d    = '0;
        error_d   = '0;
        release_c = 1'b0;
        fault_c   = 1'b0;
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    grant_d   = win_c;
                    owner_d   = win_idx_c;
                    xfer_d    = cap_xfer_c;
                    m_start_d = 1'b1;
                    state_d   = ISSUE;
                    cnt_d     = '0;
                end
            end
            ISSUE: begin
                if (bus.m_error || timeout_c) begin
                    release_c = 1'b1;
                    fault_c   = 1'b1;
                end else if (!bus.m_ready) begin
                    m_start_d = 1'b0;
                    state_d   = WAIT_DONE;
                    cnt_d     = '0;
                end
            end
            WAIT_DONE: begin
                // Error wins over a simultaneous completion.
                if (bus.m_error || timeout_c) begin
                    release_c = 1'b1;
                    fault_c   = 1'b1;
                end else if (bus.m_ready) begin
                    rdata_d = bus.m_rdata;
                    done_d  = grant_q;
                    if (bus.req_lock[owner_q]) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        release_c = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (timeout_c) begin
                    release_c = 1'b1;
                    fault_c   = 1'b1;
                end else if (bus.req_valid[owner_q]) begin
                    xfer_d    = cap_xfer_c;
                    m_start_d = 1'b1;
                    state_d   = ISSUE;
                    cnt_d     = '0;
                end else if (!bus.req_lock[owner_q]) begin
                    release_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Release: releasing owner becomes lowest priority for the next pick.
        if (release_c) begin
            grant_d   = '0;
            m_start_d = 1'b0;
            ptr_d     = owner_q;
            state_d   = IDLE;
            cnt_d     = '0;
            if (fault_c) begin
                error_d = grant_q;
            end
        end

        busy_d = |grant_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
            xfer_q    <= '0;
            m_start_q <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            xfer_q    <= xfer_d;
            m_start_q <= m_start_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.req_done   = done_q;
    assign bus.req_error  = error_q;
    assign bus.req_rdata  = rdata_q;
    assign bus.m_start    = m_start_q;
    assign bus.m_addr     = xfer_q.addr;
    assign bus.m_is_read  = xfer_q.is_read;
    assign bus.m_nb_bytes = xfer_q.nb_bytes;
    assign bus.m_wdata    = xfer_q.wdata;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Self-checking bench for tof_i2c_arbiter.
// The bench plays the sensor controllers and the I2C master; a transfer-level
// model (round-robin pointer, lock owner) predicts every grant and pulse.
module tb_tof_i2c_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 50;

    logic clk;
    logic reset;

    tof_i2c_arbiter_if #(.N_REQ(N)) bus ();

    tof_i2c_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (17)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m;
    int hold_owner;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner: first requester after the last owner, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 1; k <= int'(N); k++) begin
            t = v >> ((p + k) % int'(N));
            if (t[0]) return (p + k) % int'(N);
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int w);
        return 32'(1) << w;
    endfunction

    task automatic scramble();
        for (int i = 0; i < int'(N); i++) begin
            bus.req_addr[i]     = 16'($urandom);
            bus.req_is_read[i]  = 1'($urandom);
            bus.req_nb_bytes[i] = 17'($urandom);
            bus.req_wdata[i]    = 8'($urandom);
        end
    endtask

    // One byte transfer from arbitration (or locked recapture) to done/error.
    // Returns at the cycle where the done/error pulse is visible.
    task automatic xfer(input bit err, input bit both, input bit keep,
                        input int s1, input int s2, input int rdv);
        int          w;
        logic [15:0] ea;
        logic        er;
        logic [16:0] en;
        logic [7:0]  ew;
        logic [7:0]  rd;
        logic        lockd;
        w = (hold_owner >= 0) ? hold_owner : pick(bus.req_valid, ptr_m);
        if (w < 0) begin
            $display("FAIL xfer_setup: no requester pending");
            $fatal(1);
        end
        ea = bus.req_addr[w];
        er = bus.req_is_read[w];
        en = bus.req_nb_bytes[w];
        ew = bus.req_wdata[w];
        @(negedge clk);
        check("grant",      32'(bus.grant),      oh(w));
        check("m_start",    32'(bus.m_start),    32'd1);
        check("busy",       32'(bus.busy),       32'd1);
        check("m_addr",     32'(bus.m_addr),     32'(ea));
        check("m_is_read",  32'(bus.m_is_read),  32'(er));
        check("m_nb_bytes", 32'(bus.m_nb_bytes), 32'(en));
        check("m_wdata",    32'(bus.m_wdata),    32'(ew));
        check("done_clear", 32'(bus.req_done),   32'd0);
        check("err_clear",  32'(bus.req_error),  32'd0);
        if (!keep) bus.req_valid[w] = 1'b0;
        scramble();
        repeat (s1) begin
            @(negedge clk);
            check("start_hold", 32'(bus.m_start), 32'd1);
        end
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("start_drop", 32'(bus.m_start), 32'd0);
        check("grant_wait", 32'(bus.grant),   oh(w));
        check("frozen_addr", 32'(bus.m_addr), 32'(ea));
        repeat (s2) @(negedge clk);
        rd          = (rdv < 0) ? 8'($urandom) : 8'(rdv);
        bus.m_rdata = rd;
        bus.m_ready = err ? both : 1'b1;
        bus.m_error = err;
        lockd       = bus.req_lock[w];
        @(negedge clk);
        bus.m_error = 1'b0;
        bus.m_ready = 1'b1;
        if (err) begin
            check("err_pulse",   32'(bus.req_error), oh(w));
            check("err_no_done", 32'(bus.req_done),  32'd0);
            check("err_release", 32'(bus.grant),     32'd0);
            check("err_busy",    32'(bus.busy),      32'd0);
            ptr_m      = w;
            hold_owner = -1;
        end else begin
            check("done_pulse", 32'(bus.req_done),  oh(w));
            check("no_err",     32'(bus.req_error), 32'd0);
            check("rdata",      32'(bus.req_rdata), 32'(rd));
            if (lockd) begin
                check("hold_grant", 32'(bus.grant), oh(w));
                hold_owner = w;
            end else begin
                check("gap_grant", 32'(bus.grant), 32'd0);
                check("gap_busy",  32'(bus.busy),  32'd0);
                ptr_m      = w;
                hold_owner = -1;
            end
        end
    endtask

    initial begin
        int  w;
        bit  bad;
        logic [N-1:0] mask;

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.m_ready   = 1'b1;
        bus.m_error   = 1'b0;
        bus.m_rdata   = '0;
        scramble();
        ptr_m      = int'(N) - 1;
        hold_owner = -1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant",   32'(bus.grant),     32'd0);
        check("rst_m_start", 32'(bus.m_start),   32'd0);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_done",    32'(bus.req_done),  32'd0);
        check("rst_error",   32'(bus.req_error), 32'd0);
        check("rst_rdata",   32'(bus.req_rdata), 32'd0);
        reset = 1'b0;

        // Single read from requester 0
        bus.req_valid      = 4'b0001;
        bus.req_addr[0]    = 16'h0000;
        bus.req_is_read[0] = 1'b1;
        xfer(1'b0, 1'b0, 1'b0, 1, 9, 8'hA5);

        // Lock burst: prime pointer on requester 1 so requester 2 wins next
        bus.req_valid = 4'b0010;
        xfer(1'b0, 1'b0, 1'b0, 1, 2, -1);
        bus.req_valid = 4'b0110;
        bus.req_lock  = 4'b0100;
        for (int b = 0; b < 5; b++) begin
            bus.req_wdata[2] = 8'(8'h11 + b);
            xfer(1'b0, 1'b0, 1'b1, 0, 1, -1);
        end
        bus.req_valid[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("lock_idle_grant", 32'(bus.grant),   32'h4);
            check("lock_idle_start", 32'(bus.m_start), 32'd0);
        end
        bus.req_lock[2] = 1'b0;
        @(negedge clk);
        check("unlock_grant", 32'(bus.grant),     32'd0);
        check("unlock_error", 32'(bus.req_error), 32'd0);
        ptr_m      = 2;
        hold_owner = -1;
        xfer(1'b0, 1'b0, 1'b0, 1, 1, -1);

        // Watchdog: master never accepts the start
        bus.req_valid = 4'b1001;
        w = pick(bus.req_valid, ptr_m);
        @(negedge clk);
        check("to_grant", 32'(bus.grant), oh(w));
        bus.req_valid[w] = 1'b0;
        bad = 1'b0;
        repeat (TO - 1) begin
            @(negedge clk);
            if (bus.req_error != '0 || bus.m_start != 1'b1) bad = 1'b1;
        end
        check("to_early", 32'(bad), 32'd0);
        @(negedge clk);
        check("to_error", 32'(bus.req_error), oh(w));
        check("to_start", 32'(bus.m_start),   32'd0);
        check("to_grant_free", 32'(bus.grant), 32'd0);
        ptr_m = w;
        xfer(1'b0, 1'b0, 1'b0, 2, 3, -1);

        // Error together with m_ready in WAIT_DONE
        bus.req_valid = 4'b0100;
        xfer(1'b1, 1'b1, 1'b0, 1, 2, -1);

        // Randomized traffic
        bus.req_lock = '0;
        for (int it = 0; it < 40; it++) begin
            mask          = 4'($urandom_range(1, 15));
            bus.req_valid = mask;
            xfer(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), -1);
        end

        // Asynchronous reset in the middle of WAIT_DONE
        bus.req_valid = 4'($urandom_range(1, 15));
        w = pick(bus.req_valid, ptr_m);
        @(negedge clk);
        check("pre_rst_grant", 32'(bus.grant), oh(w));
        bus.m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_grant",   32'(bus.grant),     32'd0);
        check("arst_busy",    32'(bus.busy),      32'd0);
        check("arst_m_start", 32'(bus.m_start),   32'd0);
        check("arst_done",    32'(bus.req_done),  32'd0);
        check("arst_error",   32'(bus.req_error), 32'd0);
        check("arst_m_addr",  32'(bus.m_addr),    32'd0);
        @(negedge clk);
        bus.m_ready   = 1'b1;
        bus.req_valid = 4'hF;
        reset         = 1'b0;
        ptr_m         = int'(N) - 1;
        hold_owner    = -1;

        // Round-robin with all requesters held: 0,1,2,3,0
        repeat (5) xfer(1'b0, 1'b0, 1'b1, 1, 2, -1);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
